imem_load_ctrl: RTL
===================

// Module: imem_load_ctrl
// PURPOSE
//  Controller in front of the L1 instruction memory. It owns the memory's pc, pcwrite,
//  write_en and write-data inputs.
//  - Idle: passes fetch requests straight through from the IF stage.
//  - Boot/reload: holds the core stalled, streams a program image from a valid/ready
//    source into sequential word addresses, then issues one refetch at RESET_PC
//    before releasing the core.
//  Sits between the IF-stage PC register/hazard unit and instruction memory.
// PARAMETERS
//  IMEM_DEPTH  128          instruction memory size in 32-bit words
//  BASE_ADDR   32'h0        byte address of the first loaded word
//  RESET_PC    32'h0        byte address refetched after a successful load
//  CNT_W       $clog2(IMEM_DEPTH+1)  word-counter width (derived)
// PORTS
//  clk            in   1   system clock, all state on posedge
//  rstn           in   1   asynchronous active-low reset
//  boot_start     in   1   pulse: begin a load of boot_len words
//  boot_len       in   CNT_W  number of words to load, sampled with boot_start
//  boot_abort     in   1   pulse: cancel a load in progress
//  wr_valid       in   1   image word available
//  wr_data        in   32  image word
//  wr_ready       out  1   word accepted this cycle when wr_valid & wr_ready
//  core_pc        in   32  IF-stage fetch address
//  core_pcwrite   in   1   IF-stage fetch enable from hazard unit
//  core_stall     out  1   forces IF/ID stall while controller owns the memory
//  mem_pc         out  32  address to instruction memory
//  mem_pcwrite    out  1   memory access enable
//  mem_write_en   out  1   memory write enable
//  mem_wdata      out  32  memory write data
//  boot_done      out  1   one-cycle pulse: load finished, core released
//  boot_err       out  1   sticky: bad length or abort; cleared by next accepted boot_start
// BEHAVIOUR
//  Reset: state=IDLE, wcnt=0, len=0, boot_done=0, boot_err=0. In IDLE, wr_ready=0,
//   core_stall=0, mem_write_en=0.
//  Memory-side outputs are combinational from state/inputs. The memory registers them,
//   so a read or write takes effect at the next clk edge.
//  IDLE:
//   - mem_pc=core_pc, mem_pcwrite=core_pcwrite, mem_write_en=0, mem_wdata=0.
//   - boot_start with 1<=boot_len<=IMEM_DEPTH: latch len, wcnt<=0, boot_err<=0, go LOAD.
//   - boot_start with boot_len==0 or >IMEM_DEPTH: boot_err<=1, stay IDLE, no write.
//  LOAD:
//   - core_stall=1, wr_ready=1, mem_pc=BASE_ADDR+{wcnt,2'b00}.
//   - On wr_valid: mem_pcwrite=1, mem_write_en=1, mem_wdata=wr_data, wcnt<=wcnt+1.
//     Otherwise mem_pcwrite=0 and mem_write_en=0.
//   - Acceptance with wcnt==len-1: go FETCH. Exactly len writes, no wrap past len.
//   - boot_start is ignored. core_pc and core_pcwrite are ignored.
//  FETCH (1 cycle):
//   - core_stall=1, wr_ready=0, mem_pc=RESET_PC, mem_pcwrite=1, mem_write_en=0.
//   - Next cycle: go IDLE with boot_done=1 for exactly that one cycle.
//  boot_abort in LOAD or FETCH:
//   - Go IDLE and set boot_err=1. boot_done stays 0.
//   - Abort wins over a same-cycle wr_valid: wr_ready=0, no write. Words already
//     written stay in memory.
//   - boot_abort in IDLE is ignored.
//  Async reset mid-load returns to IDLE immediately. Partial image stays in memory;
//   no error is flagged.
//  Address arithmetic is 32-bit unsigned; wcnt never exceeds IMEM_DEPTH-1 when used as
//   an address.
// STRUCTURE
//  Shared package imem_ctrl_pkg:
//   - state enum {IDLE, LOAD, FETCH}
//   - IMEM_DEPTH default, RESET_PC default, INST_W=32
//  Single module with no sub-modules. Word counter and state register are in one
//   always block with async reset.
// TESTING
//  1. Pass-through: in IDLE, core_pc=0x10, core_pcwrite=1 -> mem_pc=0x10,
//     mem_pcwrite=1, mem_write_en=0, core_stall=0.
//  2. Load: boot_len=3 with words A,B,C, wr_valid gapped by one idle cycle ->
//     - writes at 0x0, 0x4, 0x8 only on accept cycles;
//     - FETCH drives mem_pc=0x0;
//     - boot_done pulses once; readback equals A,B,C.
//  3. Bad length: boot_len=0, then boot_len=129 -> boot_err=1, no mem_write_en.
//     Next valid boot_start clears boot_err.
//  4. Abort: boot_len=4, abort asserted with the 2nd wr_valid -> only word 0 written,
//     boot_err=1, state IDLE, boot_done=0.
//  5. Full depth: boot_len=128 with back-to-back words -> last write at 0x1FC,
//     128 writes exactly, then FETCH and boot_done.
//  6. rstn low during LOAD at word 5 -> outputs at reset values. Subsequent
//     boot_start works normally.

Source files
------------

// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory load controller.
// Address helper maps a word index to a byte address above a base.
package imem_ctrl_pkg;

  localparam int          INST_W         = 32;
  localparam int          DEF_IMEM_DEPTH = 128;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0;
  localparam int          DEF_CNT_W      = $clog2(DEF_IMEM_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2
  } state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Boot-stream, IF-stage and instruction-memory signals of the load controller.
// slave is the controller's view; master is the surrounding system's view.
interface imem_load_ctrl_if
  import imem_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic              boot_start;
  logic [CNT_W-1:0]  boot_len;
  logic              boot_abort;
  logic              wr_valid;
  logic [INST_W-1:0] wr_data;
  logic              wr_ready;
  logic [31:0]       core_pc;
  logic              core_pcwrite;
  logic              core_stall;
  logic [31:0]       mem_pc;
  logic              mem_pcwrite;
  logic              mem_write_en;
  logic [INST_W-1:0] mem_wdata;
  logic              boot_done;
  logic              boot_err;

  modport slave (
    input  boot_start, boot_len, boot_abort, wr_valid, wr_data, core_pc, core_pcwrite,
    output wr_ready, core_stall, mem_pc, mem_pcwrite, mem_write_en, mem_wdata,
           boot_done, boot_err
  );

  modport master (
    output boot_start, boot_len, boot_abort, wr_valid, wr_data, core_pc, core_pcwrite,
    input  wr_ready, core_stall, mem_pc, mem_pcwrite, mem_write_en, mem_wdata,
           boot_done, boot_err
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Owns the instruction-memory port: IF pass-through when idle, streamed image load then RESET_PC refetch.
// Memory-side outputs are combinational (memory registers them); wr_ready is held low when idle, fetching or aborting.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic           clk,
  input  logic           rstn,
  imem_load_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(IMEM_DEPTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             boot_done_q, boot_done_d;
  logic             boot_err_q, boot_err_d;

  logic             len_ok;
  logic             accept;
  logic             last_word;

  logic              wr_ready;
  logic              core_stall;
  logic [31:0]       mem_pc;
  logic              mem_pcwrite;
  logic              mem_write_en;
  logic [INST_W-1:0] mem_wdata;

  assign len_ok    = (bus.boot_len != '0) && (bus.boot_len <= CNT_W'(IMEM_DEPTH));
  // Abort takes priority over a word offered in the same cycle.
  assign accept    = (state_q == LOAD) && bus.wr_valid && !bus.boot_abort;
  assign last_word = (wcnt_q == len_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      len_q       <= '0;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      boot_done_q <= boot_done_d;
      boot_err_q  <= boot_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    boot_done_d = 1'b0;
    boot_err_d  = boot_err_q;
    case (state_q)
      IDLE: begin
        if (bus.boot_start) begin
          if (len_ok) begin
            len_d      = bus.boot_len;
            wcnt_d     = '0;
            boot_err_d = 1'b0;
            state_d    = LOAD;
          end else begin
            boot_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.boot_abort) begin
          boot_err_d = 1'b1;
          state_d    = IDLE;
        end else if (bus.wr_valid) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (last_word) state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = IDLE;
        if (bus.boot_abort) boot_err_d  = 1'b1;
        else                boot_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready     = 1'b0;
    core_stall   = 1'b0;
    mem_pc       = bus.core_pc;
    mem_pcwrite  = bus.core_pcwrite;
    mem_write_en = 1'b0;
    mem_wdata    = '0;
    case (state_q)
      LOAD: begin
        core_stall   = 1'b1;
        wr_ready     = !bus.boot_abort;
        mem_pc       = word_addr(BASE_ADDR, 32'(wcnt_q));
        mem_pcwrite  = accept;
        mem_write_en = accept;
        mem_wdata    = accept ? bus.wr_data : '0;
      end
      FETCH: begin
        core_stall  = 1'b1;
        mem_pc      = RESET_PC;
        mem_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.core_stall   = core_stall;
  assign bus.mem_pc       = mem_pc;
  assign bus.mem_pcwrite  = mem_pcwrite;
  assign bus.mem_write_en = mem_write_en;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.boot_done    = boot_done_q;
  assign bus.boot_err     = boot_err_q;

endmodule
